conv3x3_mac_engine: RTL and testbench
=====================================

Name: conv3x3_mac_engine

Overview:
- Downstream consumer of the im2col stage.
- Accepts one 9-tap unsigned pixel column per handshake and computes the dot product with a stored signed 3x3 kernel, plus bias.
- Applies ReLU, requantizes by right shift and saturates to 8 bits.
- Streams a 26x26 feature map with row/col tags and an end-of-frame pulse; 2-stage pipeline with valid/ready backpressure.

Parameters:
- DATA_W, 8, pixel/output width (pixels unsigned)
- WGT_W, 8, kernel weight width (signed)
- ACC_W, 24, accumulator and bias width (signed)
- OUT_H, 26, output rows per frame
- OUT_W, 26, output columns per frame
- QUANT_SHIFT, 7, arithmetic right shift applied before saturation

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wgt_vld_i  in  1  weight beat valid (always accepted in WLOAD)
- wgt_data_i  in  WGT_W  signed weight, taps in order e=0..8 (e=m*3+n)
- bias_i  in  ACC_W  signed bias, sampled with the 9th weight beat
- col_vld_i  in  1  column valid
- col_rdy_o  out  1  column ready
- col_data_i  in  9*DATA_W  tap e at bits [e*DATA_W +: DATA_W]
- pix_vld_o  out  1  output pixel valid
- pix_rdy_i  in  1  output pixel ready
- pix_data_o  out  DATA_W  quantized output pixel
- pix_row_o  out  5  output row index
- pix_col_o  out  5  output column index
- frame_done_o  out  1  one-cycle pulse, end of frame

Behaviour:
- Reset (also mid-operation): state=WLOAD; weights, bias and all counters cleared to 0; pipeline valids cleared; all outputs 0.
- FSM states:
  - WLOAD: each wgt_vld_i cycle writes weight[wcnt] and increments wcnt. On wcnt==8, bias_i is latched and the FSM moves to RUN next cycle.
  - RUN: columns are processed. wgt_vld_i is ignored. Weights persist across frames; reloading requires reset.
- col_rdy_o = (state==RUN) && !stall && (in_cnt < OUT_H*OUT_W), where stall = pix_vld_o && !pix_rdy_i. Handshake = col_vld_i && col_rdy_o.
- Pipeline, one global enable = !stall:
  - S1 registers the 9 products. Each pixel is zero-extended to DATA_W+1 bits, times the signed weight, giving a signed 17-bit product.
  - S2 computes sum of products + bias in ACC_W, then:
    - ReLU (negative -> 0)
    - arithmetic shift right by QUANT_SHIFT (truncating)
    - saturate to [0,255] and register into the output.
- Latency: a column accepted in cycle t gives pix_vld_o in cycle t+2 without stall. Throughput is 1 per cycle.
- While stalled, pix_data_o/row/col stay stable; no data is dropped or reordered.
- Input counter in_cnt increments per input handshake. When it reaches OUT_H*OUT_W, col_rdy_o is held low until frame end.
- Output counters col/row advance on each output handshake:
  - col wraps OUT_W-1 -> 0 and increments row.
  - A handshake at (OUT_H-1, OUT_W-1) clears row/col/in_cnt and pulses frame_done_o in the following cycle.
- Input and output handshakes in the same cycle are both honoured.

Optional Feature:
- Macro CONV3X3_RELU_EN.
- Defined: ReLU plus unsigned saturation as above.
- Undefined: no ReLU. The shifted sum saturates to signed [-128,127]; pix_data_o is two's complement.

Decomposition:
- Package conv_pkg:
  - DATA_W, WGT_W, ACC_W, KERNEL_TAPS=9, OUT_H, OUT_W
  - pixel_t, weight_t, acc_t typedefs
  - state enum {WLOAD, RUN}
- Sub-module conv3x3_dot9: 9 registered multipliers plus the adder tree (S1 and the S2 sum), with an enable input.

Test Plan:
- Weights all 1, bias 38, all taps 10 -> 90+38=128, >>7 -> pix_data_o=1 exactly 2 cycles after the column handshake, row/col=0/0.
- Weights all 1, bias 0, taps 255 -> 2295>>7=17. Weights all 127 with taps 255 -> saturates to 255.
- Weights all -1, taps 50 -> 0 with CONV3X3_RELU_EN defined; -450>>7 = -4 (0xFC) without it.
- Three back-to-back columns with pix_rdy_i low for 5 cycles -> col_rdy_o low during the stall, output held stable, all 3 results delivered in order.
- Full frame of 676 columns with pix_rdy_i=1:
  - 676 outputs; tags step (0,25) -> (1,0); last output (25,25).
  - col_rdy_o low after the 676th accept.
  - frame_done_o single pulse, then the next frame is accepted with weights retained.
- Reset asserted after 100 columns -> next cycle all outputs 0, col_rdy_o=0, state WLOAD; 9 new weights are then required before any column is accepted.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution MAC engine.
package conv_pkg;

    localparam int DATA_W      = 8;
    localparam int WGT_W       = 8;
    localparam int ACC_W       = 24;
    localparam int KERNEL_TAPS = 9;
    localparam int OUT_H       = 26;
    localparam int OUT_W       = 26;
    localparam int QUANT_SHIFT = 7;
    localparam int FRAME_PIX   = OUT_H * OUT_W;
    localparam int CNT_W       = 10;

    typedef logic [DATA_W-1:0]              pixel_t;
    typedef logic signed [WGT_W-1:0]        weight_t;
    typedef logic signed [ACC_W-1:0]        acc_t;
    typedef logic signed [DATA_W+WGT_W:0]   prod_t;

    typedef enum logic {WLOAD = 1'b0, RUN = 1'b1} state_t;

    // Unsigned pixel is zero-extended so the product keeps the weight's sign.
    function automatic prod_t tap_product(input pixel_t p, input weight_t w);
        prod_t pe;
        prod_t we;
        pe = prod_t'({1'b0, p});
        we = prod_t'(w);
        return pe * we;
    endfunction

endpackage

// File: rtl/conv3x3_dot9.sv
// Nine registered tap multipliers (stage 1) feeding a combinational adder tree with bias.
module conv3x3_dot9
    import conv_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [KERNEL_TAPS*DATA_W-1:0] pix,
    input  logic [KERNEL_TAPS*WGT_W-1:0]  wgt,
    input  logic signed [ACC_W-1:0]       bias,
    output logic signed [ACC_W-1:0]       sum
);

    prod_t prod_q [KERNEL_TAPS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < KERNEL_TAPS; e++) prod_q[e] <= '0;
        end else if (en) begin
            for (int e = 0; e < KERNEL_TAPS; e++)
                prod_q[e] <= tap_product(pix[e*DATA_W +: DATA_W], wgt[e*WGT_W +: WGT_W]);
        end
    end

    always_comb begin
        sum = bias;
        for (int e = 0; e < KERNEL_TAPS; e++) sum = sum + acc_t'(prod_q[e]);
    end

endmodule

// File: rtl/conv3x3_mac_engine.sv
// 3x3 conv MAC engine: weight load, 2-stage MAC pipeline, requantize, tagged 26x26 output.
// CONV3X3_RELU_EN selects ReLU + unsigned [0,255] output; otherwise signed [-128,127].
module conv3x3_mac_engine
    import conv_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wgt_vld_i,
    input  logic [WGT_W-1:0]              wgt_data_i,
    input  logic [ACC_W-1:0]              bias_i,
    input  logic                          col_vld_i,
    output logic                          col_rdy_o,
    input  logic [KERNEL_TAPS*DATA_W-1:0] col_data_i,
    output logic                          pix_vld_o,
    input  logic                          pix_rdy_i,
    output logic [DATA_W-1:0]             pix_data_o,
    output logic [4:0]                    pix_row_o,
    output logic [4:0]                    pix_col_o,
    output logic                          frame_done_o,
    output logic                          dbg_state
);

    state_t                       state_q, state_d;
    logic [3:0]                   wcnt;
    logic [KERNEL_TAPS*WGT_W-1:0] wgt_q;
    acc_t                         bias_q;
    logic [CNT_W-1:0]             in_cnt;
    logic                         v1;
    logic                         stall, en, in_hs, out_hs, last_pix;
    acc_t                         sum, shifted;
    pixel_t                       quant;

    // Valid/ready: a beat transfers on a cycle where valid && ready are both high;
    // a producer holds valid and data stable until that cycle.
    assign stall     = pix_vld_o && !pix_rdy_i;
    assign en        = !stall;
    assign col_rdy_o = (state_q == RUN) && !stall && (in_cnt < CNT_W'(FRAME_PIX));
    assign in_hs     = col_vld_i && col_rdy_o;
    assign out_hs    = pix_vld_o && pix_rdy_i;
    assign last_pix  = (pix_row_o == 5'(OUT_H-1)) && (pix_col_o == 5'(OUT_W-1));
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= WLOAD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WLOAD:   if (wgt_vld_i && wcnt == 4'd8) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = WLOAD;
        endcase
    end

    // Weights are only writable in WLOAD; reload requires a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt   <= '0;
            wgt_q  <= '0;
            bias_q <= '0;
        end else if (state_q == WLOAD && wgt_vld_i) begin
            for (int e = 0; e < KERNEL_TAPS; e++)
                if (wcnt == 4'(e)) wgt_q[e*WGT_W +: WGT_W] <= wgt_data_i;
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd8) bias_q <= bias_i;
        end
    end

    conv3x3_dot9 u_dot9 (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .pix   (col_data_i),
        .wgt   (wgt_q),
        .bias  (bias_q),
        .sum   (sum)
    );

    always_comb begin
        shifted = sum >>> QUANT_SHIFT;
        quant   = '0;
`ifdef CONV3X3_RELU_EN
        if (sum < 0)                      quant = '0;
        else if (shifted > acc_t'(255))   quant = 8'hFF;
        else                              quant = shifted[DATA_W-1:0];
`else
        if (shifted > acc_t'(127))        quant = 8'h7F;
        else if (shifted < acc_t'(-128))  quant = 8'h80;
        else                              quant = shifted[DATA_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1         <= 1'b0;
            pix_vld_o  <= 1'b0;
            pix_data_o <= '0;
        end else if (en) begin
            v1        <= in_hs;
            pix_vld_o <= v1;
            if (v1) pix_data_o <= quant;
        end
    end

    // Row/col tag the pixel currently on the output; they advance on its handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt       <= '0;
            pix_row_o    <= '0;
            pix_col_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= out_hs && last_pix;
            if (out_hs && last_pix) begin
                in_cnt    <= '0;
                pix_row_o <= '0;
                pix_col_o <= '0;
            end else begin
                if (in_hs) in_cnt <= in_cnt + CNT_W'(1);
                if (out_hs) begin
                    if (pix_col_o == 5'(OUT_W-1)) begin
                        pix_col_o <= '0;
                        pix_row_o <= pix_row_o + 5'd1;
                    end else begin
                        pix_col_o <= pix_col_o + 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_engine.sv
// Directed testbench for conv3x3_mac_engine; expectations follow CONV3X3_RELU_EN.
module tb_conv3x3_mac_engine;

    logic        clk;
    logic        reset;
    logic        wgt_vld_i;
    logic [7:0]  wgt_data_i;
    logic [23:0] bias_i;
    logic        col_vld_i;
    logic        col_rdy_o;
    logic [71:0] col_data_i;
    logic        pix_vld_o;
    logic        pix_rdy_i;
    logic [7:0]  pix_data_o;
    logic [4:0]  pix_row_o;
    logic [4:0]  pix_col_o;
    logic        frame_done_o;
    logic        dbg_state;

    int n_cmp;
    int n_fail;
    logic [7:0] exp_q [$];

    conv3x3_mac_engine dut (
        .clk          (clk),
        .reset        (reset),
        .wgt_vld_i    (wgt_vld_i),
        .wgt_data_i   (wgt_data_i),
        .bias_i       (bias_i),
        .col_vld_i    (col_vld_i),
        .col_rdy_o    (col_rdy_o),
        .col_data_i   (col_data_i),
        .pix_vld_o    (pix_vld_o),
        .pix_rdy_i    (pix_rdy_i),
        .pix_data_o   (pix_data_o),
        .pix_row_o    (pix_row_o),
        .pix_col_o    (pix_col_o),
        .frame_done_o (frame_done_o),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] rep9(input logic [7:0] v);
        return {9{v}};
    endfunction

    // Driver tasks
    task automatic do_reset;
        reset     = 1'b1;
        col_vld_i = 1'b0;
        wgt_vld_i = 1'b0;
        pix_rdy_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic load_weights(input logic [71:0] w, input logic [23:0] b);
        for (int i = 0; i < 9; i++) begin
            wgt_vld_i  = 1'b1;
            wgt_data_i = w[i*8 +: 8];
            bias_i     = (i == 8) ? b : 24'($urandom);
            @(posedge clk); #1;
        end
        wgt_vld_i = 1'b0;
        bias_i    = 24'($urandom);
    endtask

    task automatic send_one(input logic [71:0] taps, output logic [7:0] got,
                            output logic [4:0] grow, output logic [4:0] gcol, output bit ok);
        int n;
        ok = 1'b0; got = '0; grow = '0; gcol = '0;
        pix_rdy_i  = 1'b1;
        col_data_i = taps;
        col_vld_i  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!col_rdy_o && n < 50) begin @(negedge clk); n++; end
        if (!col_rdy_o) begin
            col_vld_i = 1'b0;
        end else begin
            @(posedge clk); #1;
            col_vld_i = 1'b0;
            n = 0;
            @(negedge clk);
            while (!pix_vld_o && n < 50) begin @(negedge clk); n++; end
            if (pix_vld_o) begin
                got = pix_data_o; grow = pix_row_o; gcol = pix_col_o; ok = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    // Scenarios
    task automatic test_reset;
        reset = 1'b1; col_vld_i = 1'b0; wgt_vld_i = 1'b0; pix_rdy_i = 1'b0;
        col_data_i = '0; wgt_data_i = '0; bias_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (pix_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_pix_vld: got %0h expected 0", pix_vld_o); end
        n_cmp++; if (pix_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_pix_data: got %0h expected 0", pix_data_o); end
        n_cmp++; if (pix_row_o !== 5'd0 || pix_col_o !== 5'd0) begin n_fail++; $display("FAIL reset_tags: got %0d/%0d expected 0/0", pix_row_o, pix_col_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %0h expected 0", frame_done_o); end
        n_cmp++; if (col_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_col_rdy: got %0h expected 0", col_rdy_o); end
        n_cmp++; if (dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0h expected 0", dbg_state); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        do_reset();
        n_cmp++; if (col_rdy_o !== 1'b0) begin n_fail++; $display("FAIL lat_rdy_wload: got %0h expected 0", col_rdy_o); end
        load_weights(rep9(8'd1), 24'd38);
        n_cmp++; if (dbg_state !== 1'b1) begin n_fail++; $display("FAIL lat_state_run: got %0h expected 1", dbg_state); end
        col_data_i = rep9(8'd10);
        col_vld_i  = 1'b1;
        @(negedge clk);
        n_cmp++; if (col_rdy_o !== 1'b1) begin n_fail++; $display("FAIL lat_col_rdy: got %0h expected 1", col_rdy_o); end
        @(posedge clk); #1;
        col_vld_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (pix_vld_o !== 1'b0) begin n_fail++; $display("FAIL lat_t1_vld: got %0h expected 0", pix_vld_o); end
        @(negedge clk);
        n_cmp++; if (pix_vld_o !== 1'b1) begin n_fail++; $display("FAIL lat_t2_vld: got %0h expected 1", pix_vld_o); end
        n_cmp++; if (pix_data_o !== 8'd1) begin n_fail++; $display("FAIL lat_data: got %0d expected 1", pix_data_o); end
        n_cmp++; if (pix_row_o !== 5'd0 || pix_col_o !== 5'd0) begin n_fail++; $display("FAIL lat_tags: got %0d/%0d expected 0/0", pix_row_o, pix_col_o); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (pix_vld_o !== 1'b0 || pix_col_o !== 5'd1) begin n_fail++; $display("FAIL lat_after_hs: got vld %0h col %0d expected 0/1", pix_vld_o, pix_col_o); end
    endtask

    task automatic test_values;
        logic [7:0]  ws  [6];
        logic [23:0] bs  [6];
        logic [7:0]  ts  [6];
        logic [7:0]  exs [6];
        logic [7:0]  got;
        logic [4:0]  gr, gc;
        bit          ok;
        ws = '{8'd1, 8'd127, 8'hFF, 8'h80, 8'd1, 8'd2};
        bs = '{24'd0, 24'd0, 24'd0, 24'd0, 24'hFFFC18, 24'd100000};
        ts = '{8'd255, 8'd255, 8'd50, 8'd255, 8'd100, 8'd0};
`ifdef CONV3X3_RELU_EN
        exs = '{8'd17, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
`else
        exs = '{8'd17, 8'h7F, 8'hFC, 8'h80, 8'hFF, 8'h7F};
`endif
        for (int i = 0; i < 6; i++) begin
            do_reset();
            load_weights(rep9(ws[i]), bs[i]);
            send_one(rep9(ts[i]), got, gr, gc, ok);
            n_cmp++;
            if (!ok || got !== exs[i]) begin
                n_fail++;
                $display("FAIL values[%0d]: got %0h (ok=%0d) expected %0h", i, got, ok, exs[i]);
            end
        end
    endtask

    task automatic test_tap_order;
        logic [71:0] w, t;
        logic [7:0]  got;
        logic [4:0]  gr, gc;
        bit          ok;
        do_reset();
        w = '0;
        w[5*8 +: 8] = 8'd64;
        load_weights(w, 24'd0);
        wgt_vld_i  = 1'b1;
        wgt_data_i = 8'h55;
        for (int e = 0; e < 9; e++) t[e*8 +: 8] = 8'(16 * (e + 1));
        send_one(t, got, gr, gc, ok);
        n_cmp++; if (!ok || got !== 8'd48) begin n_fail++; $display("FAIL tap_ramp: got %0d expected 48", got); end
        t = '0; t[5*8 +: 8] = 8'd200;
        send_one(t, got, gr, gc, ok);
        n_cmp++; if (!ok || got !== 8'd100) begin n_fail++; $display("FAIL tap5_only: got %0d expected 100", got); end
        t = '0; t[3*8 +: 8] = 8'd200;
        send_one(t, got, gr, gc, ok);
        n_cmp++; if (!ok || got !== 8'd0) begin n_fail++; $display("FAIL tap3_only: got %0d expected 0", got); end
        n_cmp++; if (gr !== 5'd0 || gc !== 5'd2) begin n_fail++; $display("FAIL tap_tags: got %0d/%0d expected 0/2", gr, gc); end
        wgt_vld_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] tbl [3];
        logic [7:0] e;
        int  n_in, n_out;
        bit  in_hs, out_hs;
        tbl = '{8'd9, 8'd4, 8'd14};
        do_reset();
        load_weights(rep9(8'd1), 24'd0);
        exp_q.delete();
        pix_rdy_i = 1'b0; col_vld_i = 1'b1; col_data_i = rep9(8'd128);
        n_in = 0; n_out = 0;
        for (int cyc = 0; cyc < 40 && n_out < 3; cyc++) begin
            @(negedge clk);
            in_hs  = col_vld_i && col_rdy_o;
            out_hs = pix_vld_o && pix_rdy_i;
            if (pix_vld_o && !pix_rdy_i) begin
                n_cmp++; if (col_rdy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_rdy: got %0h expected 0", col_rdy_o); end
                n_cmp++; if (pix_data_o !== 8'd9 || pix_col_o !== 5'd0) begin n_fail++; $display("FAIL b2b_hold: got %0d col %0d expected 9 col 0", pix_data_o, pix_col_o); end
            end
            if (out_hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++; if (pix_data_o !== e) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", n_out, pix_data_o, e); end
                n_cmp++; if (pix_col_o !== 5'(n_out)) begin n_fail++; $display("FAIL b2b_col[%0d]: got %0d expected %0d", n_out, pix_col_o, n_out); end
                n_out++;
            end
            if (in_hs) begin
                exp_q.push_back(tbl[n_in]);
                n_in++;
            end
            @(posedge clk); #1;
            if (in_hs) begin
                if (n_in == 3) col_vld_i = 1'b0;
                else           col_data_i = rep9(n_in == 1 ? 8'd64 : 8'd200);
            end
            if (cyc == 6) pix_rdy_i = 1'b1;
        end
        n_cmp++; if (n_out != 3 || n_in != 3) begin n_fail++; $display("FAIL b2b_count: got in %0d out %0d expected 3/3", n_in, n_out); end
    endtask

    task automatic test_full_frame;
        int  n_in, n_out, cyc, ev;
        int  exp_row, exp_col;
        bit  in_hs, out_hs, pend_fd;
        logic [7:0] e, got;
        logic [4:0] gr, gc;
        bit  ok;
        do_reset();
        load_weights(rep9(8'd1), 24'd0);
        exp_q.delete();
        n_in = 0; n_out = 0; cyc = 0; exp_row = 0; exp_col = 0; pend_fd = 1'b0;
        pix_rdy_i = 1'b1; col_vld_i = 1'b1; col_data_i = rep9(8'd0);
        while (n_out < 676 && cyc < 3000) begin
            @(negedge clk);
            n_cmp++; if (frame_done_o !== pend_fd) begin n_fail++; $display("FAIL ff_done_cyc%0d: got %0h expected %0h", cyc, frame_done_o, pend_fd); end
            in_hs  = col_vld_i && col_rdy_o;
            out_hs = pix_vld_o && pix_rdy_i;
            if (n_in == 676) begin
                n_cmp++; if (col_rdy_o !== 1'b0) begin n_fail++; $display("FAIL ff_rdy_full: got %0h expected 0", col_rdy_o); end
            end
            pend_fd = 1'b0;
            if (out_hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++; if (pix_data_o !== e) begin n_fail++; $display("FAIL ff_data[%0d]: got %0d expected %0d", n_out, pix_data_o, e); end
                n_cmp++; if (pix_row_o !== 5'(exp_row) || pix_col_o !== 5'(exp_col)) begin
                    n_fail++; $display("FAIL ff_tags[%0d]: got %0d/%0d expected %0d/%0d", n_out, pix_row_o, pix_col_o, exp_row, exp_col);
                end
                pend_fd = (n_out == 675);
                if (exp_col == 25) begin exp_col = 0; exp_row++; end
                else exp_col++;
                n_out++;
            end
            if (in_hs) begin
                ev = (9 * (n_in % 256)) / 128;
                exp_q.push_back(ev[7:0]);
                n_in++;
            end
            @(posedge clk); #1;
            if (in_hs) begin
                if (n_in == 676) col_vld_i = 1'b0;
                else             col_data_i = rep9(n_in[7:0]);
            end
            cyc++;
        end
        n_cmp++; if (n_out != 676 || n_in != 676) begin n_fail++; $display("FAIL ff_count: got in %0d out %0d expected 676/676", n_in, n_out); end
        @(negedge clk);
        n_cmp++; if (frame_done_o !== 1'b1) begin n_fail++; $display("FAIL ff_done_pulse: got %0h expected 1", frame_done_o); end
        n_cmp++; if (pix_row_o !== 5'd0 || pix_col_o !== 5'd0) begin n_fail++; $display("FAIL ff_tags_wrap: got %0d/%0d expected 0/0", pix_row_o, pix_col_o); end
        n_cmp++; if (col_rdy_o !== 1'b1) begin n_fail++; $display("FAIL ff_rdy_new_frame: got %0h expected 1", col_rdy_o); end
        @(negedge clk);
        n_cmp++; if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL ff_done_single: got %0h expected 0", frame_done_o); end
        @(posedge clk); #1;
        send_one(rep9(8'd255), got, gr, gc, ok);
        n_cmp++; if (!ok || got !== 8'd17 || gr !== 5'd0 || gc !== 5'd0) begin
            n_fail++; $display("FAIL ff_next_frame: got %0d at %0d/%0d (ok=%0d) expected 17 at 0/0", got, gr, gc, ok);
        end
    endtask

    task automatic test_reset_mid;
        int n, cyc;
        logic [7:0] got;
        logic [4:0] gr, gc;
        bit ok;
        do_reset();
        load_weights(rep9(8'd1), 24'd0);
        pix_rdy_i = 1'b1; col_vld_i = 1'b1; col_data_i = rep9(8'd255);
        n = 0; cyc = 0;
        while (n < 100 && cyc < 500) begin
            @(negedge clk);
            if (col_rdy_o) n++;
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        n_cmp++; if (pix_vld_o !== 1'b1 || pix_data_o !== 8'd17) begin n_fail++; $display("FAIL mid_pre_reset: got vld %0h data %0d expected 1/17", pix_vld_o, pix_data_o); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (pix_vld_o !== 1'b0 || pix_data_o !== 8'd0) begin n_fail++; $display("FAIL mid_out_clear: got vld %0h data %0d expected 0/0", pix_vld_o, pix_data_o); end
        n_cmp++; if (pix_row_o !== 5'd0 || pix_col_o !== 5'd0 || frame_done_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_tags_clear: got %0d/%0d done %0h expected 0/0 done 0", pix_row_o, pix_col_o, frame_done_o);
        end
        n_cmp++; if (col_rdy_o !== 1'b0 || dbg_state !== 1'b0) begin n_fail++; $display("FAIL mid_wload: got rdy %0h state %0h expected 0/0", col_rdy_o, dbg_state); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (col_rdy_o !== 1'b0 || pix_vld_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_accept[%0d]: got rdy %0h vld %0h expected 0/0", i, col_rdy_o, pix_vld_o); end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            wgt_vld_i = 1'b1; wgt_data_i = 8'd2; bias_i = 24'd0;
            if (i == 8) begin
                @(negedge clk);
                n_cmp++; if (col_rdy_o !== 1'b0) begin n_fail++; $display("FAIL mid_rdy_8beats: got %0h expected 0", col_rdy_o); end
            end
            @(posedge clk); #1;
        end
        wgt_vld_i = 1'b0;
        col_vld_i = 1'b0;
        send_one(rep9(8'd100), got, gr, gc, ok);
        n_cmp++; if (!ok || got !== 8'd14 || gr !== 5'd0 || gc !== 5'd0) begin
            n_fail++; $display("FAIL mid_reload: got %0d at %0d/%0d (ok=%0d) expected 14 at 0/0", got, gr, gc, ok);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_latency();
        test_values();
        test_tap_order();
        test_back_to_back();
        test_full_frame();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
